writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LANES, default 3, number of vector lanes per register.
REQ-002 Parameter LANE_W, default 18, bits per lane.
REQ-003 Parameter TIMEOUT, default 8'd64, maximum cycles spent waiting for load data.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 valid_m  in  1  memory stage presents an instruction.
REQ-007 ready_m  out  1  stage accepts the instruction this cycle; transfer when valid_m && ready_m.
REQ-008 reg_write_m  in  1  instruction writes a register.
REQ-009 mem_to_reg_m  in  1  result comes from data memory (load) rather than the ALU.
REQ-010 wa3_m  in  4  destination register index.
REQ-011 alu_result_m  in  LANES x LANE_W  ALU result, all lanes.
REQ-012 mem_rvalid  in  1  load data valid this cycle.
REQ-013 mem_rdata  in  LANES x LANE_W  load data.
REQ-014 RegWriteW  out  1  register file write enable.
REQ-015 wa3w  out  4  register file write address.
REQ-016 wd3  out  LANES x LANE_W  register file write data.
REQ-017 pc_wr_w  out  1  write to r15, redirecting the PC.
REQ-018 pc_wd_w  out  LANE_W  new PC value, taken from lane 0.
REQ-019 err  out  2  sticky error flags: bit0 = load timeout, bit1 = spurious mem_rvalid.
REQ-020 retired  out  16  count of completed instructions.

Function
REQ-021 The FSM SHALL have two states: IDLE and WAIT_MEM.
REQ-022 ready_m SHALL be 1 in IDLE and 0 in WAIT_MEM.
REQ-023 A transfer in IDLE SHALL capture reg_write_m, wa3_m and alu_result_m into the W register.
REQ-024 On a transfer with mem_to_reg_m=0, the stage SHALL stay in IDLE.
- The completion pulse occurs in the cycle after the accepting edge.
REQ-025 On a transfer with mem_to_reg_m=1, the next state SHALL be WAIT_MEM and the wait counter SHALL clear to 0.
REQ-026 In WAIT_MEM with mem_rvalid=1 at an edge, the stage SHALL replace the captured data with mem_rdata and return to IDLE.
- The completion pulse occurs in the following cycle.
REQ-027 In WAIT_MEM with mem_rvalid=0, the wait counter SHALL increment.
- When the counter reaches TIMEOUT-1 and mem_rvalid is still 0, the stage SHALL set err[0], return to IDLE and produce no write.
- A timed-out load SHALL NOT increment retired.
REQ-028 Completion pulse, lasting exactly one cycle:
- If captured reg_write=1 and wa3!=4'b1111: RegWriteW=1, with wa3w and wd3 set to the captured values.
- If reg_write=1 and wa3=4'b1111: RegWriteW=0, pc_wr_w=1, pc_wd_w=lane 0 of the data.
- If reg_write=0: no write.
- retired SHALL increment by 1 in all three cases, wrapping from 16'hFFFF to 0.
REQ-029 RegWriteW, wa3w, wd3, pc_wr_w and pc_wd_w SHALL be driven from registers, with no combinational path from inputs.
REQ-030 mem_rvalid=1 while in IDLE SHALL be ignored for data and SHALL set err[1].
REQ-031 Back-to-back transfers SHALL be supported: a non-load accepted on every edge produces a pulse on every cycle.
REQ-032 A transfer on the same edge as a load completion is impossible, because ready_m=0 in WAIT_MEM.
- The next instruction can be accepted on the first IDLE cycle.
REQ-033 err bits SHALL be cleared only by reset.

Reset
REQ-034 While rst_n=0, the following SHALL be cleared asynchronously: state=IDLE, wait counter=0, RegWriteW=0, pc_wr_w=0, wa3w=0, wd3=0, pc_wd_w=0, err=0, retired=0.
- ready_m SHALL equal 1 during reset.
REQ-035 Reset asserted during WAIT_MEM SHALL abandon the pending load.
- After release, no write is produced even if mem_rvalid arrives.
- That mem_rvalid sets err[1].

Verification
REQ-036 ALU write: transfer with wa3_m=4'd3, reg_write_m=1, mem_to_reg_m=0, alu_result_m lanes={18'h1,18'h2,18'h3} -> the next cycle has RegWriteW=1, wa3w=3, wd3 equal to those lanes, and retired=1.
REQ-037 Load with latency 3: transfer with mem_to_reg_m=1, wa3_m=5; mem_rvalid on the 3rd following edge with mem_rdata lanes=18'h3FFFF -> ready_m=0 for 3 cycles, then a single RegWriteW pulse with wd3 all 18'h3FFFF.
REQ-038 PC write: transfer with wa3_m=4'hF, reg_write_m=1, lane0=18'h00100 -> pc_wr_w=1, pc_wd_w=18'h00100, RegWriteW=0.
REQ-039 Timeout: load accepted with no mem_rvalid for 64 cycles -> err=2'b01, state IDLE, no write, retired unchanged; a later stray mem_rvalid -> err=2'b11.
REQ-040 Reset mid-load: rst_n low in WAIT_MEM, released, then mem_rvalid -> no RegWriteW, err[1]=1, retired=0.
REQ-041 Stream and wrap: 65536 back-to-back ALU transfers from retired=0 -> a pulse every cycle and retired=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: accepts ALU results directly or waits for load data,
// then issues a one-cycle register-file or PC write pulse. Tracks load
// timeouts, spurious memory responses and a retired-instruction count.
module writeback_stage #(
    parameter int          LANES   = 3,
    parameter int          LANE_W  = 18,
    parameter logic [7:0]  TIMEOUT = 8'd64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_m,
    output logic                      ready_m,
    input  logic                      reg_write_m,
    input  logic                      mem_to_reg_m,
    input  logic [3:0]                wa3_m,
    input  logic [LANES*LANE_W-1:0]   alu_result_m,
    input  logic                      mem_rvalid,
    input  logic [LANES*LANE_W-1:0]   mem_rdata,
    output logic                      RegWriteW,
    output logic [3:0]                wa3w,
    output logic [LANES*LANE_W-1:0]   wd3,
    output logic                      pc_wr_w,
    output logic [LANE_W-1:0]         pc_wd_w,
    output logic [1:0]                err,
    output logic [15:0]               retired
);

    localparam int DW = LANES * LANE_W;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [7:0]          wait_cnt_q,  wait_cnt_d;
    logic                w_reg_write_q, w_reg_write_d;
    logic [3:0]          w_wa3_q,     w_wa3_d;
    logic                reg_write_w_q, reg_write_w_d;
    logic [3:0]          wa3w_q,      wa3w_d;
    logic [DW-1:0]       wd3_q,       wd3_d;
    logic                pc_wr_w_q,   pc_wr_w_d;
    logic [LANE_W-1:0]   pc_wd_w_q,   pc_wd_w_d;
    logic [1:0]          err_q,       err_d;
    logic [15:0]         retired_q,   retired_d;

    // Completion request built by the FSM and turned into a write pulse below
    logic                complete;
    logic                comp_rw;
    logic [3:0]          comp_wa3;
    logic [DW-1:0]       comp_data;

    // Next-state, W-register capture and completion-pulse generation
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        w_reg_write_d = w_reg_write_q;
        w_wa3_d       = w_wa3_q;
        reg_write_w_d = 1'b0;
        pc_wr_w_d     = 1'b0;
        wa3w_d        = wa3w_q;
        wd3_d         = wd3_q;
        pc_wd_w_d     = pc_wd_w_q;
        err_d         = err_q;
        retired_d     = retired_q;
        complete      = 1'b0;
        comp_rw       = 1'b0;
        comp_wa3      = 4'd0;
        comp_data     = '0;

        case (state_q)
            IDLE: begin
                // Memory responses with no outstanding load are dropped and flagged
                if (mem_rvalid) begin
                    err_d[1] = 1'b1;
                end
                if (valid_m) begin
                    w_reg_write_d = reg_write_m;
                    w_wa3_d       = wa3_m;
                    if (mem_to_reg_m) begin
                        state_d    = WAIT_MEM;
                        wait_cnt_d = 8'd0;
                    end else begin
                        // ALU results complete on the accepting edge
                        complete  = 1'b1;
                        comp_rw   = reg_write_m;
                        comp_wa3  = wa3_m;
                        comp_data = alu_result_m;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    // Load data replaces the ALU value and goes straight to the write port
                    state_d   = IDLE;
                    complete  = 1'b1;
                    comp_rw   = w_reg_write_q;
                    comp_wa3  = w_wa3_q;
                    comp_data = mem_rdata;
                end else if (wait_cnt_q == TIMEOUT - 8'd1) begin
                    // Give up on the load: flag it, no write, not retired
                    err_d[0] = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete) begin
            retired_d = retired_q + 16'd1;
            if (comp_rw) begin
                if (comp_wa3 != 4'hF) begin
                    reg_write_w_d = 1'b1;
                    wa3w_d        = comp_wa3;
                    wd3_d         = comp_data;
                end else begin
                    pc_wr_w_d = 1'b1;
                    pc_wd_w_d = comp_data[LANE_W-1:0];
                end
            end
        end
    end

    // State and output registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 8'd0;
            w_reg_write_q <= 1'b0;
            w_wa3_q       <= 4'd0;
            reg_write_w_q <= 1'b0;
            wa3w_q        <= 4'd0;
            wd3_q         <= '0;
            pc_wr_w_q     <= 1'b0;
            pc_wd_w_q     <= '0;
            err_q         <= 2'b00;
            retired_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            w_reg_write_q <= w_reg_write_d;
            w_wa3_q       <= w_wa3_d;
            reg_write_w_q <= reg_write_w_d;
            wa3w_q        <= wa3w_d;
            wd3_q         <= wd3_d;
            pc_wr_w_q     <= pc_wr_w_d;
            pc_wd_w_q     <= pc_wd_w_d;
            err_q         <= err_d;
            retired_q     <= retired_d;
        end
    end

    assign ready_m   = (state_q == IDLE);
    assign RegWriteW = reg_write_w_q;
    assign wa3w      = wa3w_q;
    assign wd3       = wd3_q;
    assign pc_wr_w   = pc_wr_w_q;
    assign pc_wd_w   = pc_wd_w_q;
    assign err       = err_q;
    assign retired   = retired_q;

endmodule
